// File: rtl/io_bus_peripheral_pkg.sv
// Shared constants for the IO bus peripheral: register addresses and
// active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package io_bus_peripheral_pkg;

  localparam logic [7:0] IO_LED       = 8'h00;
  localparam logic [7:0] IO_IN_STATUS = 8'h04;
  localparam logic [7:0] IO_IN_DATA   = 8'h08;
  localparam logic [7:0] IO_SEG       = 8'h0C;
  localparam logic [7:0] IO_CNT       = 8'h10;

  localparam logic       SEG_DP_OFF = 1'b1;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/io_bus_peripheral_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import io_bus_peripheral_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // NOTE: every path assigns o_seg (default arm included), so no latch is inferred.
  always_comb begin
    o_seg = SEG_HEX_0;
    case (i_hex)
      4'h0:    o_seg = SEG_HEX_0;
      4'h1:    o_seg = SEG_HEX_1;
      4'h2:    o_seg = SEG_HEX_2;
      4'h3:    o_seg = SEG_HEX_3;
      4'h4:    o_seg = SEG_HEX_4;
      4'h5:    o_seg = SEG_HEX_5;
      4'h6:    o_seg = SEG_HEX_6;
      4'h7:    o_seg = SEG_HEX_7;
      4'h8:    o_seg = SEG_HEX_8;
      4'h9:    o_seg = SEG_HEX_9;
      4'hA:    o_seg = SEG_HEX_A;
      4'hB:    o_seg = SEG_HEX_B;
      4'hC:    o_seg = SEG_HEX_C;
      4'hD:    o_seg = SEG_HEX_D;
      4'hE:    o_seg = SEG_HEX_E;
      default: o_seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/io_bus_peripheral.sv
// Memory-mapped IO responder: LEDs, multiplexed 8-digit display, debounced
// button-qualified switch capture with valid/ack handshake, cycle counter.
module io_bus_peripheral
  import io_bus_peripheral_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [16:0] SCAN_DIV        = 17'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  logic [15:0] r_led;
  logic [31:0] r_seg_data;
  logic [31:0] r_cnt;
  logic        r_in_valid;
  logic [15:0] r_sw_latched;

  logic        r_btn_s1, r_btn_s2;
  logic [15:0] r_sw_s1, r_sw_s2;
  logic [15:0] r_db_cnt;
  logic        r_btn_db, r_btn_db_d;
  logic        r_armed;

  logic [16:0] r_scan_cnt;
  logic [2:0]  r_digit;

  logic        w_wr_led, w_wr_seg, w_wr_cnt, w_ack;
  logic        w_rise, w_take;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex;
  logic [31:0] w_din;

  assign w_wr_led = io_we && (io_addr == IO_LED);
  assign w_ack    = io_we && (io_addr == IO_IN_STATUS);
  assign w_wr_seg = io_we && (io_addr == IO_SEG);
  assign w_wr_cnt = io_we && (io_addr == IO_CNT);

  // A held button at reset release must not count as a press: r_armed
  // only rises once the synced level has been seen low.
  assign w_rise = r_btn_db && !r_btn_db_d && r_armed;
  assign w_take = w_rise && (!r_in_valid || w_ack);

  // NOTE: synchronizer flops carry no reset; they only track the pins, and
  // keeping the live level through reset is what lets r_armed see a held button.
  always_ff @(posedge clk) begin
    r_btn_s1 <= btn;
    r_btn_s2 <= r_btn_s1;
    r_sw_s1  <= sw;
    r_sw_s2  <= r_sw_s1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led        <= '0;
      r_seg_data   <= '0;
      r_cnt        <= '0;
      r_in_valid   <= 1'b0;
      r_sw_latched <= '0;
      r_db_cnt     <= '0;
      r_btn_db     <= 1'b0;
      r_btn_db_d   <= 1'b0;
      r_armed      <= 1'b0;
      r_scan_cnt   <= '0;
      r_digit      <= '0;
    end else begin
      if (w_wr_led) r_led      <= io_dout[15:0];
      if (w_wr_seg) r_seg_data <= io_dout;
      r_cnt <= w_wr_cnt ? io_dout : r_cnt + 32'd1;

      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_btn_db <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
      r_btn_db_d <= r_btn_db;
      if (!r_btn_s2) r_armed <= 1'b1;

      // An accepted edge beats a coincident acknowledge.
      if (w_take) begin
        r_in_valid   <= 1'b1;
        r_sw_latched <= r_sw_s2;
      end else if (w_ack) begin
        r_in_valid <= 1'b0;
      end

      if (r_scan_cnt == SCAN_DIV - 17'd1) begin
        r_scan_cnt <= '0;
        r_digit    <= r_digit + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 17'd1;
      end
    end
  end

  always_comb begin
    w_din = '0;
    case (io_addr)
      IO_LED:       w_din = {16'b0, r_led};
      IO_IN_STATUS: w_din = {31'b0, r_in_valid};
      IO_IN_DATA:   w_din = {16'b0, r_sw_latched};
      IO_SEG:       w_din = r_seg_data;
      IO_CNT:       w_din = r_cnt;
      default:      w_din = '0;
    endcase
  end

  assign w_nibble = r_seg_data[{r_digit, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .i_hex (w_nibble),
    .o_seg (w_hex)
  );

  assign io_din = w_din;
  assign led    = r_led;
  assign an     = ~(8'h01 << r_digit);
  assign seg    = {SEG_DP_OFF, w_hex};

endmodule
